// File: rtl/jesd204b_pkg.sv
// Shared JESD204B link-layer constants, state encoding and ILAS configuration helpers.
// Used by both the TX and RX link layers.
package jesd204b_pkg;

    localparam int K_PARAM  = 16;
    localparam int F_OCTETS = 4;
    localparam int ILAS_MF  = 4;

    localparam logic [7:0] K_28_5 = 8'hBC;  // /K/ comma
    localparam logic [7:0] CHAR_A = 8'h7C;  // /A/ multiframe end
    localparam logic [7:0] CHAR_R = 8'h1C;  // /R/ multiframe start
    localparam logic [7:0] CHAR_F = 8'hFC;  // /F/ frame end
    localparam logic [7:0] CHAR_Q = 8'h9C;  // /Q/ config start

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CGS       = 3'd1,
        ST_ILAS      = 3'd2,
        ST_USER_DATA = 3'd3
    } link_state_t;

    // Configuration octets 0..12 of the ILAS second multiframe.
    function automatic logic [7:0] ilas_cfg_field(input logic [3:0] idx, input logic [7:0] did,
                                                  input logic [3:0] bid, input logic [4:0] lid,
                                                  input logic scr);
        case (idx)
            4'd0:    return did;
            4'd1:    return {4'h0, bid};
            4'd2:    return {3'h0, lid};
            4'd3:    return {scr, 7'h00};
            4'd4:    return 8'(F_OCTETS - 1);
            4'd5:    return 8'(K_PARAM - 1);
            4'd6:    return 8'h01;
            4'd7:    return 8'h0F;
            4'd8:    return 8'h0F;
            default: return 8'h00;
        endcase
    endfunction

    // Octet 13 is the checksum of octets 0..12.
    function automatic logic [7:0] ilas_cfg_octet(input logic [3:0] idx, input logic [7:0] did,
                                                  input logic [3:0] bid, input logic [4:0] lid,
                                                  input logic scr);
        logic [7:0] sum;
        sum = 8'h00;
        if (idx == 4'd13) begin
            for (int j = 0; j < 13; j++) sum = sum + ilas_cfg_field(4'(j), did, bid, lid, scr);
            return sum;
        end
        return ilas_cfg_field(idx, did, bid, lid, scr);
    endfunction

endpackage

// File: rtl/jesd204b_tx_link_layer_if.sv
// Sample input and lane output bundle of the JESD204B TX link layer.
// data_req acts as ready with an implied always-valid source: the sample on adc_data0/1 is
// consumed at every clock edge where data_req=1; the source must update it each such cycle.
interface jesd204b_tx_link_layer_if;
    logic [15:0] adc_data0;
    logic [15:0] adc_data1;
    logic        data_req;
    logic [31:0] tx_parallel_data;
    logic [3:0]  tx_datak;

    modport master (input adc_data0, adc_data1, output data_req, tx_parallel_data, tx_datak);
    modport slave  (output adc_data0, adc_data1, input data_req, tx_parallel_data, tx_datak);
endinterface

// File: rtl/jesd204b_scrambler.sv
// 32-bit parallel self-synchronizing scrambler, 1+x^14+x^15, bit 31 first, registered output.
// The 15-bit state holds the last 15 scrambled bits, so the far-end descrambler needs no seed.
module jesd204b_scrambler (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        en,
    input  logic        bypass,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);
    logic [14:0] state_q;
    logic [14:0] sr;
    logic [31:0] scr;

    // sr[0] is the most recent scrambled bit, sr[13]/sr[14] are 14/15 bits back.
    always_comb begin
        sr  = state_q;
        scr = '0;
        for (int i = 31; i >= 0; i--) begin
            scr[i] = data_in[i] ^ sr[13] ^ sr[14];
            sr     = {sr[13:0], scr[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= '0;
            data_out <= '0;
        end else if (en) begin
            if (bypass) begin
                data_out <= data_in;
            end else begin
                data_out <= scr;
                state_q  <= sr;
            end
        end
    end
endmodule

// File: rtl/jesd204b_tx_link_layer.sv
// JESD204B TX link layer, one lane, F=4 K=16: CGS, 4-multiframe ILAS, then user data
// with optional scrambling and octet-3 character replacement. Two-stage output pipeline.
module jesd204b_tx_link_layer
    import jesd204b_pkg::*;
#(
    parameter logic [7:0] DID = 8'h00,
    parameter logic [3:0] BID = 4'h0,
    parameter logic [4:0] LID = 5'h00
) (
    input  logic                          clk,
    input  logic                          reset_b,
    input  logic                          sync_b,
    input  logic                          sysref,
    input  logic                          scrambler_is_on,
    jesd204b_tx_link_layer_if.master      lnk,
    output logic [2:0]                    link_state
);
    link_state_t state, next_state;
    logic        sync_ff1, sync_s, sync_low_q, resync;
    logic        sysref_d, sysref_edge_q;
    logic [3:0]  lmfc_cnt;
    logic [5:0]  frame_cnt;
    logic [3:0]  fr_cnt;
    logic [1:0]  mf_cnt;
    logic        data_req_q;
    logic        in_link, next_in_link;
    logic [31:0] ilas_word;
    logic [3:0]  ilas_k;
    logic [31:0] s1_word;
    logic [3:0]  s1_k;
    logic        s1_is_data;
    logic [3:0]  s1_fr;
    logic [31:0] scr_word;
    logic [7:0]  prev_oct3;
    logic        prev_valid;
    logic [31:0] data_tx;
    logic [3:0]  data_k;
    logic [31:0] tx_q;
    logic [3:0]  k_q;

    assign fr_cnt = frame_cnt[3:0];
    assign mf_cnt = frame_cnt[5:4];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync_ff1   <= 1'b1;
            sync_s     <= 1'b1;
            sync_low_q <= 1'b0;
        end else begin
            sync_ff1   <= sync_b;
            sync_s     <= sync_ff1;
            sync_low_q <= ~sync_s;
        end
    end

    assign resync = ~sync_s & sync_low_q;

    // LMFC restarts at 0 the cycle after the registered SYSREF edge.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sysref_d      <= 1'b0;
            sysref_edge_q <= 1'b0;
            lmfc_cnt      <= 4'd0;
        end else begin
            sysref_d      <= sysref;
            sysref_edge_q <= sysref & ~sysref_d;
            lmfc_cnt      <= sysref_edge_q ? 4'd0 : lmfc_cnt + 4'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      next_state = ST_CGS;
            ST_CGS:       if (sync_s && lmfc_cnt == 4'(K_PARAM - 1)) next_state = ST_ILAS;
            ST_ILAS: begin
                if (resync) next_state = ST_CGS;
                else if (mf_cnt == 2'(ILAS_MF - 1) && fr_cnt == 4'(K_PARAM - 1))
                    next_state = ST_USER_DATA;
            end
            ST_USER_DATA: if (resync) next_state = ST_CGS;
            default:      next_state = ST_IDLE;
        endcase
    end

    assign in_link      = (state == ST_ILAS) || (state == ST_USER_DATA);
    assign next_in_link = (next_state == ST_ILAS) || (next_state == ST_USER_DATA);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state      <= ST_IDLE;
            frame_cnt  <= 6'd0;
            data_req_q <= 1'b0;
        end else begin
            state      <= next_state;
            frame_cnt  <= (in_link && next_in_link) ? frame_cnt + 6'd1 : 6'd0;
            data_req_q <= (next_state == ST_USER_DATA);
        end
    end

    assign link_state   = state;
    assign lnk.data_req = data_req_q;

    // Ramp data with /R/, /A/, /Q/ and configuration octets overlaid.
    always_comb begin
        ilas_k = 4'h0;
        for (int i = 0; i < 4; i++) ilas_word[8*i +: 8] = {2'b00, fr_cnt, 2'(i)};
        if (fr_cnt == 4'd0) begin
            ilas_word[7:0] = CHAR_R;
            ilas_k[0]      = 1'b1;
        end
        if (fr_cnt == 4'(K_PARAM - 1)) begin
            ilas_word[31:24] = CHAR_A;
            ilas_k[3]        = 1'b1;
        end
        if (mf_cnt == 2'd1) begin
            if (fr_cnt == 4'd0) begin
                ilas_word[15:8]  = CHAR_Q;
                ilas_k[1]        = 1'b1;
                ilas_word[23:16] = ilas_cfg_octet(4'd0, DID, BID, LID, scrambler_is_on);
                ilas_word[31:24] = ilas_cfg_octet(4'd1, DID, BID, LID, scrambler_is_on);
            end else if (fr_cnt <= 4'd3) begin
                for (int i = 0; i < 4; i++)
                    ilas_word[8*i +: 8] = ilas_cfg_octet({fr_cnt[1:0], 2'(i)} - 4'd2,
                                                         DID, BID, LID, scrambler_is_on);
            end
        end
    end

    jesd204b_scrambler u_scrambler (
        .clk      (clk),
        .reset_b  (reset_b),
        .en       (data_req_q),
        .bypass   (~scrambler_is_on),
        .data_in  ({lnk.adc_data0, lnk.adc_data1}),
        .data_out (scr_word)
    );

    // Stage 1 control word runs alongside the scrambler register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s1_word    <= '0;
            s1_k       <= '0;
            s1_is_data <= 1'b0;
            s1_fr      <= '0;
        end else begin
            s1_is_data <= (state == ST_USER_DATA);
            s1_fr      <= fr_cnt;
            case (state)
                ST_CGS: begin
                    s1_word <= {4{K_28_5}};
                    s1_k    <= 4'hF;
                end
                ST_ILAS: begin
                    s1_word <= ilas_word;
                    s1_k    <= ilas_k;
                end
                default: begin
                    s1_word <= '0;
                    s1_k    <= '0;
                end
            endcase
        end
    end

    // Scrambled word bit 31 is the first bit on the wire, so octet 0 comes from [31:24].
    always_comb begin
        data_tx = {scr_word[7:0], scr_word[15:8], scr_word[23:16], scr_word[31:24]};
        data_k  = 4'h0;
        if (scrambler_is_on) begin
            if (s1_fr == 4'(K_PARAM - 1)) data_k[3] = (scr_word[7:0] == CHAR_A);
            else                          data_k[3] = (scr_word[7:0] == CHAR_F);
        end else if (prev_valid && scr_word[7:0] == prev_oct3) begin
            data_tx[31:24] = (s1_fr == 4'(K_PARAM - 1)) ? CHAR_A : CHAR_F;
            data_k[3]      = 1'b1;
        end
    end

    // CGS bypasses stage 1 so a resync shows up one cycle after the state change.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_q       <= '0;
            k_q        <= '0;
            prev_oct3  <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev_valid <= s1_is_data;
            if (s1_is_data) prev_oct3 <= scr_word[7:0];
            case (state)
                ST_IDLE: begin
                    tx_q <= '0;
                    k_q  <= '0;
                end
                ST_CGS: begin
                    tx_q <= {4{K_28_5}};
                    k_q  <= 4'hF;
                end
                default: begin
                    tx_q <= s1_is_data ? data_tx : s1_word;
                    k_q  <= s1_is_data ? data_k  : s1_k;
                end
            endcase
        end
    end

    assign lnk.tx_parallel_data = tx_q;
    assign lnk.tx_datak         = k_q;
endmodule

// File: tb/tb_jesd204b_tx_link_layer.sv
// Directed bench for the JESD204B TX link layer: CGS, ILAS layout and alignment,
// raw-data character replacement, resync, and scrambled data recovered by a descrambler.
module tb_jesd204b_tx_link_layer;
    import jesd204b_pkg::*;

    localparam logic [31:0] ILAS0 = 32'h0302011C;
    localparam logic [31:0] ILAS15 = 32'h7C3E3D3C;
    localparam logic [31:0] CGS_W = 32'hBCBCBCBC;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        sync_b;
    logic        sysref;
    logic        scrambler_is_on;
    logic [2:0]  link_state;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          sysref_cyc;
    int          n;
    int          got;
    int          fr_exp;
    logic [1:0]  dr_hist;
    logic        first;
    logic [14:0] rx_prev;
    logic [31:0] w, d, e;
    logic [46:0] ext;
    logic        expk;
    logic [31:0] exp_q[$];

    jesd204b_tx_link_layer_if lnk_if ();

    jesd204b_tx_link_layer dut (
        .clk             (clk),
        .reset_b         (reset_b),
        .sync_b          (sync_b),
        .sysref          (sysref),
        .scrambler_is_on (scrambler_is_on),
        .lnk             (lnk_if),
        .link_state      (link_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_word(input logic [31:0] target, input int limit, output int cnt);
        cnt = 0;
        while (lnk_if.tx_parallel_data !== target && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] wd, input logic [3:0] k);
        check(tag, lnk_if.tx_parallel_data, wd);
        check({tag, "_k"}, 32'(lnk_if.tx_datak), 32'(k));
    endtask

    initial begin
        reset_b = 1'b0;
        sync_b = 1'b0;
        sysref = 1'b0;
        scrambler_is_on = 1'b0;
        lnk_if.adc_data0 = 16'h1234;
        lnk_if.adc_data1 = 16'h5678;
        tick();
        tick();
        check_word("reset_tx", 32'h0, 4'h0);
        check("reset_data_req", 32'(lnk_if.data_req), 32'd0);
        check("reset_state", 32'(link_state), 32'd0);

        // Held SYNC~ low: continuous comma stream
        reset_b = 1'b1;
        tick();
        check("idle_to_cgs", 32'(link_state), 32'd1);
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check_word("cgs_word", CGS_W, 4'hF);
            check("cgs_state", 32'(link_state), 32'd1);
        end

        // SYSREF pulse then SYNC~ release: ILAS word 0 on the LMFC boundary
        sysref = 1'b1;
        tick();
        sysref = 1'b0;
        sysref_cyc = cyc;
        tick();
        sync_b = 1'b1;
        wait_word(ILAS0, 60, n);
        check_word("ilas0", ILAS0, 4'h1);
        check("ilas0_latency", 32'(cyc - sysref_cyc), 32'd19);

        for (int j = 1; j <= 80; j++) begin
            tick();
            case (j)
                15: check_word("ilas_a0", ILAS15, 4'h8);
                16: check_word("ilas_q", 32'h00009C1C, 4'h3);
                17: check_word("ilas_cfg2", 32'h0F030000, 4'h0);
                18: check_word("ilas_cfg6", 32'h000F0F01, 4'h0);
                19: check_word("ilas_fchk", 32'h31000000, 4'h0);
                20: check_word("ilas_ramp4", 32'h13121110, 4'h0);
                31: check_word("ilas_a1", ILAS15, 4'h8);
                32: check_word("ilas_r2", ILAS0, 4'h1);
                47: check_word("ilas_a2", ILAS15, 4'h8);
                48: check_word("ilas_r3", ILAS0, 4'h1);
                61: begin
                    check_word("ilas_ramp13", 32'h37363534, 4'h0);
                    check("ilas_data_req", 32'(lnk_if.data_req), 32'd0);
                    check("ilas_state", 32'(link_state), 32'd2);
                end
                62: begin
                    check("user_data_req", 32'(lnk_if.data_req), 32'd1);
                    check("user_state", 32'(link_state), 32'd3);
                end
                63: check_word("ilas_last", ILAS15, 4'h8);
                64: check_word("user_first", 32'h78563412, 4'h0);
                65: check_word("user_f1", 32'hFC563412, 4'h8);
                78: check_word("user_f14", 32'hFC563412, 4'h8);
                79: check_word("user_a15", 32'h7C563412, 4'h8);
                80: check_word("user_f16", 32'hFC563412, 4'h8);
                default: ;
            endcase
        end

        // One-cycle SYNC~ glitch is ignored
        sync_b = 1'b0;
        tick();
        sync_b = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("glitch_state", 32'(link_state), 32'd3);
        check("glitch_data_req", 32'(lnk_if.data_req), 32'd1);

        // Sustained SYNC~ low: CGS after 5 cycles
        sync_b = 1'b0;
        wait_word(CGS_W, 12, n);
        check_word("resync_cgs", CGS_W, 4'hF);
        check("resync_latency", 32'(n), 32'd5);
        check("resync_state", 32'(link_state), 32'd1);
        check("resync_data_req", 32'(lnk_if.data_req), 32'd0);

        // Fresh ILAS on the next LMFC boundary
        sync_b = 1'b1;
        wait_word(ILAS0, 60, n);
        check_word("reilas0", ILAS0, 4'h1);
        check("reilas_align", 32'((cyc - sysref_cyc) % 16), 32'd3);
        check("reilas_state", 32'(link_state), 32'd2);

        // Scrambler on, from a fresh reset
        reset_b = 1'b0;
        scrambler_is_on = 1'b1;
        lnk_if.adc_data0 = 16'h8000;
        lnk_if.adc_data1 = 16'h0000;
        tick();
        tick();
        reset_b = 1'b1;
        wait_word(ILAS0, 60, n);
        check_word("scr_ilas0", ILAS0, 4'h1);
        for (int j = 1; j <= 19; j++) begin
            tick();
            case (j)
                16: check_word("scr_ilas_q", 32'h00009C1C, 4'h3);
                17: check_word("scr_ilas_cfg2", 32'h0F038000, 4'h0);
                18: check_word("scr_ilas_cfg6", 32'h000F0F01, 4'h0);
                19: check_word("scr_ilas_fchk", 32'hB1000000, 4'h0);
                default: ;
            endcase
        end

        dr_hist = 2'b00;
        fr_exp = 0;
        first = 1'b1;
        rx_prev = '0;
        got = 0;
        for (int t = 0; t < 200 && got < 24; t++) begin
            tick();
            if (dr_hist[1]) begin
                w = {lnk_if.tx_parallel_data[7:0], lnk_if.tx_parallel_data[15:8],
                     lnk_if.tx_parallel_data[23:16], lnk_if.tx_parallel_data[31:24]};
                ext = {rx_prev, w};
                for (int i = 0; i < 32; i++) d[i] = ext[i] ^ ext[i+14] ^ ext[i+15];
                rx_prev = w[14:0];
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                check("scr_recovered", d, e);
                if (got == 0) check_word("scr_first", 32'h0A000380, 4'h0);
                expk = (fr_exp == 15) ? (w[7:0] == CHAR_A) : (w[7:0] == CHAR_F);
                check("scr_datak", 32'(lnk_if.tx_datak), 32'({expk, 3'b000}));
                fr_exp = (fr_exp + 1) % 16;
                got++;
            end
            dr_hist = {dr_hist[0], lnk_if.data_req};
            if (lnk_if.data_req) begin
                if (!first) begin
                    lnk_if.adc_data0 = 16'($urandom_range(0, 65535));
                    lnk_if.adc_data1 = 16'($urandom_range(0, 65535));
                end
                first = 1'b0;
                exp_q.push_back({lnk_if.adc_data0, lnk_if.adc_data1});
            end
        end
        check("scr_count", 32'(got), 32'd24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
